// File: rtl/bus_memory_model.sv
// Cycle-accurate memory/vector responder for the top8227 external bus.
// Serves zero-latency reads, commits CPU writes, and halts on a stop-address write.
module bus_memory_model #(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    DEPTH        = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 16'h0000,
    parameter logic [DATA_WIDTH-1:0] FILL_BYTE    = 8'hEA,
    parameter logic [15:0]           NMI_VECTOR   = 16'h0000,
    parameter logic [15:0]           RESET_VECTOR = 16'hCCDD,
    parameter logic [15:0]           IRQ_VECTOR   = 16'h0000,
    parameter logic [ADDR_WIDTH-1:0] STOP_ADDR    = 16'h00FF,
    parameter int                    CNT_WIDTH    = 16,
    localparam int                   IDX_WIDTH    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [7:0]            AddressBusHigh,
    input  logic [7:0]            AddressBusLow,
    input  logic                  cpu_write,
    input  logic [DATA_WIDTH-1:0] dataBusOutput,
    output logic [DATA_WIDTH-1:0] dataBusInput,
    input  logic                  load_valid,
    input  logic [IDX_WIDTH-1:0]  load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ready,
    input  logic                  run,
    output logic                  halted,
    output logic [DATA_WIDTH-1:0] result,
    output logic [CNT_WIDTH-1:0]  read_count,
    output logic [CNT_WIDTH-1:0]  write_count
);

    if (DEPTH < 16 || DEPTH > 4096 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
        $error("bus_memory_model: DEPTH must be a power of two in 16..4096");
    end
    if (64'(BASE_ADDR) + 64'(DEPTH) > (64'd1 << ADDR_WIDTH)) begin : gBadWindow
        $error("bus_memory_model: storage window wraps past the top of the address space");
    end

    typedef enum logic [1:0] {LOAD, RUN, HALT} modeType;

    localparam logic [ADDR_WIDTH-1:0] VECTOR_LOW = {ADDR_WIDTH{1'b1}} - ADDR_WIDTH'(5);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT  = (ADDR_WIDTH + 1)'(DEPTH);

    modeType                 stateReg;
    modeType                 stateNext;
    logic [ADDR_WIDTH-1:0]   cpuAddr;
    logic [ADDR_WIDTH-1:0]   windowOffset;
    logic [IDX_WIDTH-1:0]    memIdx;
    logic                    isVector;
    logic                    inWindow;
    logic                    isStop;
    logic [15:0]             vectorWord;
    logic [DATA_WIDTH-1:0]   vectorByte;
    logic                    memWe;
    logic [IDX_WIDTH-1:0]    memWriteIdx;
    logic [DATA_WIDTH-1:0]   memWriteData;
    logic                    loadReady;
    logic                    isRun;
    logic                    isHalt;
    logic [DATA_WIDTH-1:0]   resultReg;
    logic [CNT_WIDTH-1:0]    readCountReg;
    logic [CNT_WIDTH-1:0]    writeCountReg;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // ---------------- address decode ----------------
    assign cpuAddr      = ADDR_WIDTH'({AddressBusHigh, AddressBusLow});
    assign windowOffset = cpuAddr - BASE_ADDR;
    assign memIdx       = windowOffset[IDX_WIDTH-1:0];
    assign isVector     = cpuAddr >= VECTOR_LOW;
    assign inWindow     = (cpuAddr >= BASE_ADDR) && ({1'b0, windowOffset} < DEPTH_EXT);
    assign isStop       = cpuAddr == STOP_ADDR;

    always_comb begin
        vectorWord = IRQ_VECTOR;
        case (cpuAddr[2:1])
            2'b01:   vectorWord = NMI_VECTOR;
            2'b10:   vectorWord = RESET_VECTOR;
            default: vectorWord = IRQ_VECTOR;
        endcase
        vectorByte = cpuAddr[0] ? DATA_WIDTH'(vectorWord[15:8]) : DATA_WIDTH'(vectorWord[7:0]);
    end

    // Vectors win over an overlapping storage window; the array read is combinational,
    // so a same-cycle write is only visible from the next cycle.
    always_comb begin
        if (isVector)
            dataBusInput = vectorByte;
        else if (inWindow)
            dataBusInput = mem[memIdx];
        else
            dataBusInput = FILL_BYTE;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            stateReg <= LOAD;
        else
            stateReg <= stateNext;
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            LOAD:    if (run) stateNext = RUN;
            RUN:     if (cpu_write && isStop) stateNext = HALT;
            HALT:    stateNext = HALT;
            default: stateNext = LOAD;
        endcase
    end

    always_comb begin
        loadReady = (stateReg == LOAD) && nrst;
        isRun     = stateReg == RUN;
        isHalt    = stateReg == HALT;
    end

    assign load_ready = loadReady;
    assign halted     = isHalt;

    // ---------------- storage write port ----------------
    always_comb begin
        memWe        = 1'b0;
        memWriteIdx  = load_addr;
        memWriteData = load_data;
        if (nrst) begin
            if (loadReady) begin
                memWe = load_valid;
            end else if (isRun) begin
                memWe        = cpu_write && inWindow;
                memWriteIdx  = memIdx;
                memWriteData = dataBusOutput;
            end
        end
    end

    // Storage deliberately has no reset so a program survives a mid-run reset.
    always_ff @(posedge clk) begin
        if (memWe)
            mem[memWriteIdx] <= memWriteData;
    end

    // ---------------- result and saturating counters ----------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            resultReg     <= '0;
            readCountReg  <= '0;
            writeCountReg <= '0;
        end else if (isRun) begin
            if (cpu_write) begin
                if (writeCountReg != {CNT_WIDTH{1'b1}})
                    writeCountReg <= writeCountReg + CNT_WIDTH'(1);
                if (isStop)
                    resultReg <= dataBusOutput;
            end else if (readCountReg != {CNT_WIDTH{1'b1}}) begin
                readCountReg <= readCountReg + CNT_WIDTH'(1);
            end
        end
    end

    assign result      = resultReg;
    assign read_count  = readCountReg;
    assign write_count = writeCountReg;

endmodule

// File: doc/bus_memory_model.md
Name: bus_memory_model

Overview:
- Parametrised, cycle-accurate memory/vector responder attached to the top8227 external bus; replaces hand-sequenced dataBusInput stimulus in benches.
- Serves read data from a preloadable byte array, commits CPU writes, and maps the NMI/RESET/IRQ vectors to parameter values.
- Detects a write to a stop address for self-terminating programs and keeps saturating access counters.

Parameters:
- ADDR_WIDTH, 16, CPU address width (AddressBusHigh concatenated with AddressBusLow).
- DATA_WIDTH, 8, bus data width.
- DEPTH, 256, bytes of backing storage; power of two, 16..4096.
- BASE_ADDR, 16'h0000, first CPU address mapped to storage entry 0.
- FILL_BYTE, 8'hEA, read value for unmapped addresses.
- NMI_VECTOR, 16'h0000, returned at FFFA (low byte) / FFFB (high byte).
- RESET_VECTOR, 16'hCCDD, returned at FFFC / FFFD.
- IRQ_VECTOR, 16'h0000, returned at FFFE / FFFF.
- STOP_ADDR, 16'h00FF, a CPU write here halts the model.
- CNT_WIDTH, 16, width of the access counters.

Ports:
- clk  in  1  system clock.
- nrst  in  1  asynchronous active-low reset.
- AddressBusHigh  in  8  CPU address high byte.
- AddressBusLow  in  8  CPU address low byte.
- cpu_write  in  1  CPU write strobe for the current cycle.
- dataBusOutput  in  DATA_WIDTH  CPU write data.
- dataBusInput  out  DATA_WIDTH  read data to CPU.
- load_valid  in  1  preload request.
- load_addr  in  log2(DEPTH)  preload storage index.
- load_data  in  DATA_WIDTH  preload byte.
- load_ready  out  1  preload accepted this cycle.
- run  in  1  release from preload into run mode.
- halted  out  1  stop-address write seen.
- result  out  DATA_WIDTH  byte written to STOP_ADDR.
- read_count  out  CNT_WIDTH  CPU reads serviced.
- write_count  out  CNT_WIDTH  CPU writes committed.

Behaviour:
- Reset (async, nrst=0):
  - State goes to LOAD; halted=0, result=0, both counters=0, load_ready=0.
  - Storage is not cleared; dataBusInput follows the read decode.
- FSM states: LOAD, RUN, HALT.
  - LOAD: load_ready=1. On a posedge with load_valid=1, load_data is written to mem[load_addr]. CPU writes are ignored and counters hold. run=1 moves to RUN next cycle. If load_valid and run are both high, the load commits and the state then moves to RUN.
  - RUN: load_ready=0 and load_valid is ignored. If cpu_write=1 at a posedge: when addr==STOP_ADDR, result<=dataBusOutput and the state moves to HALT (storage is also written if the address is mapped); otherwise mapped storage is written and unmapped writes are dropped. write_count increments for every write, including STOP_ADDR and dropped writes. A cycle with cpu_write=0 increments read_count. Counters saturate at all-ones.
  - HALT: halted=1; writes are ignored and counters freeze. Exit is by reset only, which also drops run back to LOAD.
- Read decode (combinational, zero latency, all states), addr = {AddressBusHigh, AddressBusLow}, in priority order:
  1. FFFA..FFFF return the vector bytes, low byte at the even address.
  2. BASE_ADDR <= addr < BASE_ADDR+DEPTH returns mem[addr-BASE_ADDR], using unsigned subtraction at ADDR_WIDTH.
  3. Otherwise FILL_BYTE.
- Vector addresses take priority even if the storage window overlaps them; a window overlapping FFFA..FFFF is legal.
- A window that wraps past FFFF is not supported. Elaboration fails if BASE_ADDR+DEPTH > 2^ADDR_WIDTH.
- Read-during-write to the same address returns the old byte this cycle and the new byte from the next cycle.
- Reset asserted mid-program: state, counters and halted clear immediately; memory contents persist, so a re-run without reload is valid.

Test Plan:
- Reset decode: nrst=0, then address FFFC -> dataBusInput=DD; FFFD -> CC; FFFB -> 00. Unmapped 8000 -> EA.
- Preload: LOAD state, write A9 to index 0 and 10 to index 1; assert run; present addresses 0000 and 0001 -> A9 then 10. Load_valid in RUN has no effect; load_ready=0.
- CPU write and read-back: RUN, cpu_write=1, addr 0042, data 5A -> same-cycle read shows old byte, next cycle shows 5A. write_count=1.
- Halt: write 7E to 00FF -> halted=1 and result=7E on the next cycle. A following write to 0010 is ignored; counters hold.
- Counter saturation (CNT_WIDTH=4): 20 read cycles -> read_count=F. A write then increments write_count independently.
- Mid-run reset: halted=1, pulse nrst low for 1 cycle -> halted=0, counters 0, state LOAD. The earlier 5A at 0042 is still readable.
